// File: rtl/pwm_seq_ctrl_if.sv
// Control/status bundle between the register block and pwm_seq_ctrl.
// The irq signal exists only when PWM_SEQ_IRQ_EN is defined.
interface pwm_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ctrl;
    logic                  ctrl_wr;
    logic                  pwm_out;
    logic [DATA_WIDTH-1:0] status_out;
`ifdef PWM_SEQ_IRQ_EN
    logic                  irq;

    modport master (output ctrl, ctrl_wr, input pwm_out, status_out, irq);
    modport slave  (input ctrl, ctrl_wr, output pwm_out, status_out, irq);
`else
    modport master (output ctrl, ctrl_wr, input pwm_out, status_out);
    modport slave  (input ctrl, ctrl_wr, output pwm_out, status_out);
`endif
endinterface

// File: rtl/pwm_seq_ctrl.sv
// PWM sequencer: decodes CTRL, keeps period/duty shadows updated at wraps, drives PWM and STATUS.
// Optional macro PWM_SEQ_IRQ_EN adds a one-cycle wrap interrupt (irq, STATUS[3]).
module pwm_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    pwm_seq_ctrl_if.slave bus
);
    localparam int P = CNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [P-1:0]          r_cnt;
    logic [P-1:0]          r_period_sh;
    logic [P-1:0]          r_duty_sh;
    logic                  r_upd_pend;
    logic [7:0]            r_per_cnt;
    logic                  r_pwm;
    logic [DATA_WIDTH-1:0] r_status;
    logic [DATA_WIDTH-1:0] w_status_next;

    logic                  w_en;
    logic                  w_pol;
    logic                  w_oneshot;
    logic [P-1:0]          w_period;
    logic [P-1:0]          w_duty;
    logic                  w_wrap;
    logic                  w_reload;
    logic                  w_unused_ctrl;

    assign w_en      = bus.ctrl[0];
    assign w_pol     = bus.ctrl[1];
    assign w_oneshot = bus.ctrl[2];
    assign w_period  = bus.ctrl[4 +: P];
    assign w_duty    = bus.ctrl[4+P +: P];
    assign w_unused_ctrl = ^bus.ctrl;

    assign w_wrap = (r_state == S_RUN) && (r_cnt == r_period_sh);

`ifdef PWM_SEQ_IRQ_EN
    logic w_irqen;
    logic w_irq_next;
    logic r_irq;

    assign w_irqen    = bus.ctrl[3];
    assign w_irq_next = w_wrap && w_irqen;
    assign bus.irq    = r_irq;
`endif

    // A wrap only reloads shadows when the sequencer stays in RUN
    always_comb begin
        w_next_state = r_state;
        w_reload     = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_en) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_RUN;
            S_RUN: begin
                if (w_wrap) begin
                    if (!w_en) begin
                        w_next_state = S_IDLE;
                    end else if (w_oneshot) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_reload = r_upd_pend;
                    end
                end
            end
            S_DONE: if (!w_en) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_status_next       = '0;
        w_status_next[0]    = (r_state == S_RUN);
        w_status_next[1]    = r_upd_pend;
        w_status_next[2]    = (r_state == S_DONE);
        w_status_next[15:8] = r_per_cnt;
`ifdef PWM_SEQ_IRQ_EN
        w_status_next[3]    = w_irq_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_upd_pend  <= 1'b0;
            r_per_cnt   <= '0;
            r_pwm       <= 1'b0;
            r_status    <= '0;
`ifdef PWM_SEQ_IRQ_EN
            r_irq       <= 1'b0;
`endif
        end else begin
            r_state  <= w_next_state;
            r_pwm    <= ((r_state == S_RUN) && (r_cnt < r_duty_sh)) ? ~w_pol : w_pol;
            r_status <= w_status_next;
`ifdef PWM_SEQ_IRQ_EN
            r_irq    <= w_irq_next;
`endif
            unique case (r_state)
                S_IDLE: r_cnt <= '0;
                S_LOAD: begin
                    r_period_sh <= w_period;
                    r_duty_sh   <= w_duty;
                    r_cnt       <= '0;
                    r_upd_pend  <= 1'b0;
                    r_per_cnt   <= '0;
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_cnt     <= '0;
                        r_per_cnt <= r_per_cnt + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A write landing on the wrap cycle wins, deferring to the next wrap
                    if (bus.ctrl_wr) begin
                        r_upd_pend <= 1'b1;
                    end else if (w_reload) begin
                        r_upd_pend <= 1'b0;
                    end
                    if (w_reload) begin
                        r_period_sh <= w_period;
                        r_duty_sh   <= w_duty;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pwm_out    = r_pwm;
    assign bus.status_out = r_status;
endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
- Sequencer between the register interface and the PWM output.
- Takes the software CTRL word and decodes enable, mode, period and duty.
- Holds shadow copies of period and duty that change only at period boundaries, runs the period counter and drives the PWM output.
- Returns a STATUS word that the register block samples into its read-only STATUS register.

Parameters:
- DATA_WIDTH, 32: width of ctrl and status words.
- CNT_WIDTH, 12: period/duty counter width; legal range 1..14 (4+2*CNT_WIDTH <= DATA_WIDTH).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- ctrl  input  DATA_WIDTH  CTRL register value.
- ctrl_wr  input  1  one-cycle pulse coincident with a CTRL write (the ctrl input shows the new value from the next cycle).
- pwm_out  output  1  registered PWM output.
- status_out  output  DATA_WIDTH  flags to the register block.

CTRL field map (P = CNT_WIDTH):
- [0] EN
- [1] POL: 1 = active-low output
- [2] ONESHOT
- [3] IRQEN
- [4+P-1:4] PERIOD
- [4+2P-1:4+P] DUTY

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, cnt=0, period_sh=0, duty_sh=0, upd_pend=0, per_cnt=0.
  - pwm_out=0, status_out=0. Reset applies mid-operation with no completion of the current period.
- Inactive level = POL. Active level = ~POL.
- pwm_out is a flop: pwm_out(t+1) = (state(t)==RUN && cnt(t) < duty_sh) ? ~POL : POL. The output therefore lags cnt by one cycle.
- Period length = PERIOD+1 cycles (cnt runs 0..period_sh).
- Duty:
  - DUTY=0: output never active.
  - DUTY > PERIOD: output always active (no special clamp logic needed beyond the compare).
- FSM:
  - IDLE: cnt=0. When EN=1, go to LOAD.
  - LOAD (1 cycle):
    - period_sh<=PERIOD, duty_sh<=DUTY, cnt<=0, upd_pend<=0, per_cnt<=0.
    - Then go to RUN.
  - RUN:
    - If cnt<period_sh: cnt<=cnt+1.
    - If cnt==period_sh (wrap): cnt<=0, per_cnt<=per_cnt+1 (8-bit, wraps 255->0). Then, in priority order:
      1. EN=0: go to IDLE (a disable never truncates a period).
      2. ONESHOT=1: go to DONE.
      3. upd_pend=1: reload shadows from ctrl and clear upd_pend; stay in RUN.
      4. Otherwise stay in RUN.
  - DONE: output inactive. When EN=0, go to IDLE.
- upd_pend:
  - Set by ctrl_wr while state==RUN.
  - If ctrl_wr and a wrap occur in the same cycle, upd_pend ends at 1 and the new value loads at the following wrap.
  - ctrl_wr in IDLE, LOAD or DONE is ignored (LOAD samples ctrl directly).
- status_out:
  - [0] busy (state==RUN)
  - [1] upd_pend
  - [2] done (state==DONE)
  - [15:8] per_cnt
  - all other bits 0
  - Registered: reflects state one cycle after it changes.

Optional Feature:
- Macro PWM_SEQ_IRQ_EN.
- Defined:
  - Adds port irq (output, 1 bit, reset 0), registered.
  - irq pulses high for exactly one cycle after each RUN wrap when IRQEN=1.
  - status_out[3] mirrors irq.
- Undefined:
  - No irq port.
  - ctrl[3] ignored.
  - status_out[3]=0.

Test Plan:
- Reset then ctrl={EN=1,POL=0,PERIOD=3,DUTY=2} -> LOAD next cycle; pwm_out repeats 1,1,0,0 (4-cycle period); per_cnt increments every 4 cycles; status[0]=1.
- While running PERIOD=3/DUTY=2, write DUTY=1 with ctrl_wr mid-period -> status[1]=1 until the wrap; the following period reads 1,0,0,0; status[1] returns to 0.
- Clear EN at cnt=1 -> the current period completes fully, then IDLE; pwm_out=POL; status[0]=0.
- ONESHOT=1, PERIOD=2, DUTY=1 -> exactly one period 1,0,0, then DONE with status[2]=1; clearing EN returns to IDLE.
- Edge values and polarity:
  - DUTY=0 -> pwm_out constantly inactive.
  - DUTY=5 with PERIOD=3 -> constantly active.
  - POL=1 -> both levels inverted.
  - Hold reset_n=0 for one edge mid-run -> all outputs 0 and state IDLE.
- With PWM_SEQ_IRQ_EN defined, IRQEN=1, PERIOD=3 -> irq is a one-cycle pulse every 4 cycles; per_cnt wraps 255->0 after 256 periods.
